// File: rtl/sm_decode_pkg.sv
// Shared definitions for the decode queue: instruction field positions,
// reserved opcode_na values and the packed bundle of decoded fields.
package sm_decode_pkg;

  // Number of low instruction bits that carry decodable fields.
  localparam int DEC_INST_W = 64;

  // Field bit positions inside the instruction word.
  localparam int OPC_NA_LSB = 0;
  localparam int OPC_NA_MSB = 3;
  localparam int MOD_LSB    = 4;
  localparam int MOD_MSB    = 9;
  localparam int PR_LSB     = 10;
  localparam int PR_MSB     = 13;
  localparam int RE0_LSB    = 14;
  localparam int RE0_MSB    = 19;
  localparam int RE1_LSB    = 20;
  localparam int RE1_MSB    = 25;
  localparam int IMMEB_LSB  = 26;
  localparam int IMMEB_MSB  = 35;
  localparam int IMMEA_LSB  = 36;
  localparam int IMMEA_MSB  = 57;
  localparam int OPC_NB_LSB = 58;
  localparam int OPC_NB_MSB = 63;

  // opcode_na encodings that no legal instruction uses.
  localparam logic [3:0] OPC_NA_RSVD_E = 4'hE;
  localparam logic [3:0] OPC_NA_RSVD_F = 4'hF;

  // Decoded view of one instruction word.
  typedef struct packed {
    logic [5:0]  opcode_nb;
    logic [21:0] immea;
    logic [9:0]  immeb;
    logic [5:0]  re1;
    logic [5:0]  re0;
    logic [3:0]  pr;
    logic [5:0]  mod;
    logic [3:0]  opcode_na;
  } dec_fields_t;

  // Slice an instruction word into its fields.
  function automatic dec_fields_t decode_fields(input logic [DEC_INST_W-1:0] inst);
    dec_fields_t f;
    f.opcode_na = inst[OPC_NA_MSB:OPC_NA_LSB];
    f.mod       = inst[MOD_MSB:MOD_LSB];
    f.pr        = inst[PR_MSB:PR_LSB];
    f.re0       = inst[RE0_MSB:RE0_LSB];
    f.re1       = inst[RE1_MSB:RE1_LSB];
    f.immeb     = inst[IMMEB_MSB:IMMEB_LSB];
    f.immea     = inst[IMMEA_MSB:IMMEA_LSB];
    f.opcode_nb = inst[OPC_NB_MSB:OPC_NB_LSB];
    return f;
  endfunction

  // True for an opcode_na value reserved for future use.
  function automatic logic is_reserved_opc_na(input logic [3:0] opc);
    return (opc == OPC_NA_RSVD_E) || (opc == OPC_NA_RSVD_F);
  endfunction

endpackage

// File: rtl/sm_inst_fifo.sv
// Circular FIFO holding instruction entries: storage, read/write pointers
// and occupancy count. Flush clears pointers and count; storage is cleared
// only by reset.
module sm_inst_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 68
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic [DATA_W-1:0]            data_i,
  input  logic                         flush_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [DATA_W-1:0]            data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, pop;

  // Advance a pointer, wrapping from DEPTH-1 back to 0.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // Handshake: full-ness alone gates ready, so a pop never frees a slot early.
  assign ready_o = (count_q < CNT_W'(DEPTH));
  assign valid_o = (count_q != '0);
  assign push    = valid_i && ready_o;
  assign pop     = valid_o && ready_i;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Next pointer and count values; flush overrides any push or pop.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; a write in a flush cycle is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: storage is reset on purpose so the head outputs read zero during and right after reset.
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push && !flush_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/sm_decode_queue.sv
// Instruction decode queue: buffers (instruction, warp id) pairs and decodes
// the fields of the head entry combinationally.
// Optional feature: define SM_DECODE_ILLEGAL_CHK_EN to flag reserved
// opcode_na values at the head on illegal_o; otherwise illegal_o is 0.
`ifndef DEPTH_WARP
`define DEPTH_WARP 4
`endif
`ifndef CODE_MEM_DATA_WIDTH
`define CODE_MEM_DATA_WIDTH 64
`endif

module sm_decode_queue
  import sm_decode_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int WID_W  = `DEPTH_WARP,
  parameter int INST_W = `CODE_MEM_DATA_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic [INST_W-1:0]           inst_i,
  input  logic [WID_W-1:0]            wid_i,
  input  logic                        flush_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [INST_W-1:0]           inst_o,
  output logic [WID_W-1:0]            wid_o,
  output logic [3:0]                  opcode_na_o,
  output logic [5:0]                  mod_o,
  output logic [3:0]                  pr_o,
  output logic [5:0]                  re0_o,
  output logic [5:0]                  re1_o,
  output logic [9:0]                  immeb_o,
  output logic [21:0]                 immea_o,
  output logic [5:0]                  opcode_nb_o,
  output logic [$clog2(DEPTH+1)-1:0]  count_o,
  output logic                        illegal_o
);

  localparam int ENT_W = WID_W + INST_W;

  logic [ENT_W-1:0] head_ent;
  dec_fields_t      head_f;

  sm_inst_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (ENT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  ({wid_i, inst_i}),
    .flush_i (flush_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (head_ent),
    .count_o (count_o)
  );

  assign {wid_o, inst_o} = head_ent;

  // Field extraction from the head entry; stable while the head is held.
  assign head_f      = decode_fields(inst_o[DEC_INST_W-1:0]);
  assign opcode_na_o = head_f.opcode_na;
  assign mod_o       = head_f.mod;
  assign pr_o        = head_f.pr;
  assign re0_o       = head_f.re0;
  assign re1_o       = head_f.re1;
  assign immeb_o     = head_f.immeb;
  assign immea_o     = head_f.immea;
  assign opcode_nb_o = head_f.opcode_nb;

`ifdef SM_DECODE_ILLEGAL_CHK_EN
  assign illegal_o = valid_o && is_reserved_opc_na(head_f.opcode_na);
`else
  assign illegal_o = 1'b0;
`endif

endmodule
